// File: rtl/uart_mem_ctrl_pkg.sv
// Shared definitions for the UART memory load/dump controller:
// FSM state encoding, mode / memory-select constants and a byte-lane helper.
package uart_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD_BYTE   = 3'd1,
    LOAD_WRITE  = 3'd2,
    DUMP_READ   = 3'd3,
    DUMP_WAIT   = 3'd4,
    DUMP_SEND   = 3'd5,
    DUMP_TXWAIT = 3'd6,
    DONE        = 3'd7
  } state_t;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_DUMP = 1'b1;
  localparam logic RAM_INST  = 1'b0;
  localparam logic RAM_DATA  = 1'b1;

  // Little-endian byte lane of a 32-bit word (lane 0 = bits [7:0]).
  function automatic logic [7:0] lane_of(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_mem_ctrl_packer.sv
// uart_word_packer: byte<->word lane handling shared by the load and dump paths.
// Holds the byte index counter and the word assembly register. On the load side
// each written byte lands in lane idx; on the dump side lane idx of word_i is
// presented on lane_o. The 2-bit index wraps after lane 3, so a new word always
// starts at lane 0 without an explicit clear.
module uart_word_packer
  import uart_mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        wr_i,
  input  logic        adv_i,
  input  logic [7:0]  byte_i,
  input  logic [31:0] word_i,
  output logic [1:0]  idx_o,
  output logic [31:0] asm_next_o,
  output logic [7:0]  lane_o
);

  logic [1:0]  idx_q;
  logic [31:0] asm_q;

  // Assembly word with the incoming byte merged into the current lane.
  always_comb begin
    asm_next_o = asm_q;
    asm_next_o[{idx_q, 3'b000} +: 8] = byte_i;
  end

  assign lane_o = lane_of(word_i, idx_q);
  assign idx_o  = idx_q;

  // Byte index and assembly register; clear has priority over write/advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q <= 2'd0;
      asm_q <= 32'd0;
    end else if (clr_i) begin
      idx_q <= 2'd0;
      asm_q <= 32'd0;
    end else if (wr_i) begin
      asm_q <= asm_next_o;
      idx_q <= idx_q + 2'd1;
    end else if (adv_i) begin
      idx_q <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/uart_mem_ctrl.sv
// uart_mem_ctrl: sequences UART load (RX -> memory) and dump (memory -> TX)
// sessions while holding the CPU. Words are little-endian, 4 bytes each.
// Optional feature macro: UART_CHECKSUM_EN -- running mod-256 byte sum on
// xfer_sum and a trailing checksum byte at the end of a dump.
// TX handshake: tx_start is a one-cycle pulse issued only when tx_busy=0; the
// TX engine raises tx_busy the cycle after the pulse and lowers it when the
// byte is gone, so tx_busy is ignored in the first cycle after the pulse.
module uart_mem_ctrl
  import uart_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_on,
  input  logic                  uart_mode,
  input  logic                  uart_ram_id,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  mem_sel,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [7:0]            xfer_sum,
  output logic [2:0]            dbg_state
);

`ifdef UART_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                state_q;
  logic                  mem_sel_q, mem_we_q, tx_start_q, first_q, sum_phase_q;
  logic [7:0]            tx_data_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q, rdata_q;
  logic [ADDR_WIDTH:0]   count_q, count_inc;
  logic                  pk_clr, pk_wr, pk_adv, tx_fire, byte_done, last_word;
  logic [1:0]            pk_idx;
  logic [31:0]           pk_asm_next;
  logic [7:0]            pk_lane;

  assign count_inc = count_q + 1'b1;
  assign last_word = (count_inc == DEPTH_W);
  assign tx_fire   = (state_q == DUMP_SEND) && uart_on && !tx_busy;
  assign byte_done = (state_q == DUMP_TXWAIT) && !first_q && !tx_busy;
  assign pk_clr    = (state_q == IDLE);
  assign pk_wr     = uart_on && rx_valid && ((state_q == LOAD_BYTE) || (state_q == LOAD_WRITE));
  assign pk_adv    = byte_done && uart_on && !sum_phase_q;

  uart_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (pk_clr),
    .wr_i       (pk_wr),
    .adv_i      (pk_adv),
    .byte_i     (rx_data),
    .word_i     (rdata_q),
    .idx_o      (pk_idx),
    .asm_next_o (pk_asm_next),
    .lane_o     (pk_lane)
  );

  // Session FSM with registered strobes, address and word counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_sel_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      rdata_q     <= 32'd0;
      count_q     <= '0;
      first_q     <= 1'b0;
      sum_phase_q <= 1'b0;
    end else begin
      mem_we_q   <= 1'b0;
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (uart_on) begin
            mem_sel_q   <= (uart_ram_id == RAM_DATA) ? RAM_DATA : RAM_INST;
            count_q     <= '0;
            mem_addr_q  <= '0;
            sum_phase_q <= 1'b0;
            state_q     <= (uart_mode == MODE_DUMP) ? DUMP_READ : LOAD_BYTE;
          end
        end
        LOAD_BYTE: begin
          if (!uart_on) begin
            state_q <= IDLE;
          end else if (rx_valid && (pk_idx == 2'd3)) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= pk_asm_next;
            state_q     <= LOAD_WRITE;
          end
        end
        LOAD_WRITE: begin
          mem_addr_q <= mem_addr_q + 1'b1;
          count_q    <= count_inc;
          if (!uart_on)      state_q <= IDLE;
          else if (last_word) state_q <= DONE;
          else               state_q <= LOAD_BYTE;
        end
        DUMP_READ: state_q <= uart_on ? DUMP_WAIT : IDLE;
        DUMP_WAIT: begin
          rdata_q <= mem_rdata;
          state_q <= uart_on ? DUMP_SEND : IDLE;
        end
        DUMP_SEND: begin
          if (!uart_on) begin
            state_q <= IDLE;
          end else if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= sum_phase_q ? xfer_sum : pk_lane;
            first_q    <= 1'b1;
            state_q    <= DUMP_TXWAIT;
          end
        end
        DUMP_TXWAIT: begin
          if (first_q) begin
            first_q <= 1'b0;
          end else if (!tx_busy) begin
            if (!uart_on) begin
              state_q <= IDLE;
            end else if (sum_phase_q) begin
              state_q <= DONE;
            end else if (pk_idx == 2'd3) begin
              mem_addr_q <= mem_addr_q + 1'b1;
              count_q    <= count_inc;
              if (!last_word) begin
                state_q <= DUMP_READ;
              end else if (CSUM_EN) begin
                sum_phase_q <= 1'b1;
                state_q     <= DUMP_SEND;
              end else begin
                state_q <= DONE;
              end
            end else begin
              state_q <= DUMP_SEND;
            end
          end
        end
        DONE:    if (!uart_on) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef UART_CHECKSUM_EN
  logic [7:0] sum_q;
  // Running byte sum: cleared at session start, adds each received or sent data byte.
  always_ff @(posedge clk) begin
    if (!reset)                         sum_q <= 8'd0;
    else if ((state_q == IDLE) && uart_on) sum_q <= 8'd0;
    else if (pk_wr)                     sum_q <= sum_q + rx_data;
    else if (tx_fire && !sum_phase_q)   sum_q <= sum_q + pk_lane;
  end
  assign xfer_sum = sum_q;
`else
  assign xfer_sum = 8'h00;
`endif

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign mem_sel    = mem_sel_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = count_q;
  assign cpu_hold   = (state_q != IDLE);
  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// Testbench for uart_mem_ctrl (DEPTH=4). Memory and TX engine are modelled
// here; written words and transmitted bytes are checked against queues of
// expected values filled when stimulus is driven.
module tb_uart_mem_ctrl;
  import uart_mem_ctrl_pkg::*;

  localparam int AW    = 8;
  localparam int DEPTH = 4;
`ifdef UART_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b0;
  logic          uart_on = 1'b0, uart_mode = 1'b0, uart_ram_id = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          tx_busy = 1'b0;
  logic          tx_start, mem_sel, mem_we, cpu_hold, busy, done;
  logic [7:0]    tx_data, xfer_sum;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [AW:0]   word_count;
  logic [2:0]    dbg_state;

  int         n_checks = 0, n_fail = 0;
  int         hold_bad = 0, tx_viol = 0, busy_cnt = 0;
  logic       hold_chk = 1'b0;
  logic [7:0] exp_q[$];
  logic [40:0] exp_wr_q[$];
  logic [31:0] words[4];
  logic [7:0] exp_sum;

  uart_mem_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .uart_on(uart_on), .uart_mode(uart_mode),
    .uart_ram_id(uart_ram_id), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .mem_sel(mem_sel),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .word_count(word_count),
    .xfer_sum(xfer_sum), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory and TX engine models ----------------
  logic [31:0] mem [0:511];
  always @(posedge clk) begin
    if (mem_we) mem[{mem_sel, mem_addr}] <= mem_wdata;
    mem_rdata <= mem[{mem_sel, mem_addr}];
  end

  always @(posedge clk) begin
    if (!reset) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      busy_cnt <= $urandom_range(2, 5);
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_busy <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [40:0] ew;
    logic [7:0]  eb;
    if (hold_chk && (cpu_hold !== 1'b1)) hold_bad++;
    if (mem_we) begin
      n_checks++;
      if (exp_wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL mem_write: got sel=%0d addr=%0d data=%h, required no write", mem_sel, mem_addr, mem_wdata);
      end else begin
        ew = exp_wr_q.pop_front();
        if ({mem_sel, mem_addr, mem_wdata} !== ew) begin
          n_fail++;
          $display("FAIL mem_write: got sel=%0d addr=%0d data=%h, required sel=%0d addr=%0d data=%h",
                   mem_sel, mem_addr, mem_wdata, ew[40], ew[39:32], ew[31:0]);
        end
      end
    end
    if (tx_start) begin
      if (tx_busy) tx_viol++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_byte: got %h, required no byte", tx_data);
      end else begin
        eb = exp_q.pop_front();
        if (tx_data !== eb) begin
          n_fail++;
          $display("FAIL tx_byte: got %h, required %h", tx_data, eb);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Loads words[] into the given memory; mode/ram_id are toggled mid-session.
  task automatic do_load(input logic ram, input int gap_max, output bit ok);
    logic [7:0] bt;
    @(negedge clk);
    uart_mode = MODE_LOAD; uart_ram_id = ram; uart_on = 1'b1;
    @(negedge clk);
    uart_mode = MODE_DUMP; uart_ram_id = ~ram;
    hold_chk = 1'b1;
    exp_sum = 8'd0;
    for (int w = 0; w < 4; w++) begin
      exp_wr_q.push_back({ram, w[7:0], words[w]});
      for (int b = 0; b < 4; b++) begin
        bt = words[w][b*8 +: 8];
        exp_sum = exp_sum + bt;
        send_byte(bt, $urandom_range(0, gap_max));
      end
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    hold_chk = 1'b0;
  endtask

  task automatic start_dump(input logic ram);
    @(negedge clk);
    uart_mode = MODE_DUMP; uart_ram_id = ram; uart_on = 1'b1;
  endtask

  task automatic wait_done(input int max, output bit ok, output int nbytes);
    ok = 1'b0; nbytes = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tx_start) nbytes++;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic end_session();
    @(negedge clk);
    uart_on = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_dump_bytes();
    logic [7:0] bt;
    exp_sum = 8'd0;
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++) begin
        bt = words[w][b*8 +: 8];
        exp_sum = exp_sum + bt;
        exp_q.push_back(bt);
      end
    if (CSUM) exp_q.push_back(exp_sum);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_start, tx_data, mem_sel, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, word_count, xfer_sum} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got tx_start=%b tx_data=%h we=%b addr=%h hold=%b busy=%b done=%b wc=%0d, required all 0",
               tx_start, tx_data, mem_we, mem_addr, cpu_hold, busy, done, word_count);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, IDLE); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    bit ok;
    words[0] = 32'h12345678; words[1] = 32'hDEADBEEF; words[2] = 32'h0BADF00D; words[3] = 32'h55AA33CC;
    hold_bad = 0;
    do_load(1'b1, 3, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL load_done: got done=%b after timeout, required 1", done); end
    n_checks++;
    if (hold_bad !== 0) begin n_fail++; $display("FAIL load_cpu_hold: got %0d low cycles, required 0", hold_bad); end
    n_checks++;
    if ({mem_sel, word_count, busy, cpu_hold} !== {1'b1, 9'd4, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL load_status: got sel=%b wc=%0d busy=%b hold=%b, required sel=1 wc=4 busy=0 hold=1", mem_sel, word_count, busy, cpu_hold);
    end
    n_checks++;
    if (xfer_sum !== (CSUM ? exp_sum : 8'h00)) begin
      n_fail++; $display("FAIL load_sum: got %h, required %h", xfer_sum, CSUM ? exp_sum : 8'h00);
    end
    n_checks++;
    if (exp_wr_q.size() != 0) begin n_fail++; $display("FAIL load_writes: got %0d missing writes, required 0", exp_wr_q.size()); end
    end_session();
    n_checks++;
    if ({cpu_hold, done} !== 2'b00) begin n_fail++; $display("FAIL load_release: got hold=%b done=%b, required 0 0", cpu_hold, done); end
  endtask

  task automatic test_abort_load();
    words[0] = 32'hA5A50001;
    @(negedge clk);
    uart_mode = MODE_LOAD; uart_ram_id = RAM_INST; uart_on = 1'b1;
    @(negedge clk);
    exp_wr_q.push_back({1'b0, 8'd0, words[0]});
    for (int b = 0; b < 4; b++) send_byte(words[0][b*8 +: 8], 1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 2);
    uart_on = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cpu_hold, busy, dbg_state} !== {1'b0, 1'b0, IDLE}) begin
      n_fail++; $display("FAIL abort_idle: got hold=%b busy=%b state=%0d, required 0 0 0", cpu_hold, busy, dbg_state);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_wr_q.size() != 0 || word_count !== 9'd1) begin
      n_fail++; $display("FAIL abort_writes: got pending=%0d wc=%0d, required 0 and 1", exp_wr_q.size(), word_count);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int nb;
    words[0] = 32'hA4A3A2A1; words[1] = 32'hB4B3B2B1; words[2] = 32'hC4C3C2C1; words[3] = 32'hD4D3D2D1;
    @(negedge clk);
    uart_mode = MODE_LOAD; uart_ram_id = RAM_DATA; uart_on = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 4; w++) exp_wr_q.push_back({1'b1, w[7:0], words[w]});
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++) begin
        if (w > 0 && b == 0) begin
          n_checks++;
          if (mem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_overlap: got mem_we=%b with next byte, required 1", mem_we); end
        end
        rx_valid = 1'b1;
        rx_data  = words[w][b*8 +: 8];
        @(negedge clk);
      end
    rx_valid = 1'b0;
    wait_done(10, ok, nb);
    n_checks++;
    if (!ok || exp_wr_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_done: got done=%b pending=%0d, required 1 and 0", done, exp_wr_q.size());
    end
    end_session();
  endtask

  task automatic test_dump();
    bit ok;
    int nbytes;
    words[0] = 32'hCAFEBABE; words[1] = $urandom; words[2] = $urandom; words[3] = $urandom;
    do_load(RAM_INST, 2, ok);
    end_session();
    push_dump_bytes();
    tx_viol = 0;
    start_dump(RAM_INST);
    ok = 1'b0; nbytes = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (tx_start) begin
        n_checks++;
        if (word_count !== 9'(nbytes / 4)) begin
          n_fail++; $display("FAIL dump_word_count: byte %0d got wc=%0d, required %0d", nbytes, word_count, nbytes / 4);
        end
        nbytes++;
      end
      if (done) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || nbytes != (CSUM ? 17 : 16) || exp_q.size() != 0) begin
      n_fail++; $display("FAIL dump_done: got done=%b bytes=%0d pending=%0d, required 1 %0d 0", done, nbytes, exp_q.size(), CSUM ? 17 : 16);
    end
    n_checks++;
    if (tx_viol != 0) begin n_fail++; $display("FAIL dump_tx_busy: got %0d starts while busy, required 0", tx_viol); end
    n_checks++;
    if ({word_count, mem_sel, xfer_sum} !== {9'd4, 1'b0, (CSUM ? exp_sum : 8'h00)}) begin
      n_fail++; $display("FAIL dump_status: got wc=%0d sel=%b sum=%h, required 4 0 %h", word_count, mem_sel, xfer_sum, CSUM ? exp_sum : 8'h00);
    end
    end_session();
  endtask

  task automatic test_reset_mid_dump();
    bit ok;
    int nb;
    words[0] = 32'h12345678; words[1] = 32'h9ABCDEF0; words[2] = 32'h0F1E2D3C; words[3] = 32'h4B5A6978;
    do_load(RAM_DATA, 1, ok);
    end_session();
    exp_q.push_back(8'h78);
    start_dump(RAM_DATA);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_state == DUMP_TXWAIT) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mid_dump_reach: got state=%0d, required %0d", dbg_state, DUMP_TXWAIT); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tx_start, tx_data, mem_sel, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, word_count, xfer_sum} !== '0) begin
      n_fail++;
      $display("FAIL mid_dump_reset: got tx_start=%b tx_data=%h sel=%b addr=%h hold=%b busy=%b wc=%0d, required all 0",
               tx_start, tx_data, mem_sel, mem_addr, cpu_hold, busy, word_count);
    end
    uart_on = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_dump_first: got %0d pending, required 0", exp_q.size()); end
    push_dump_bytes();
    start_dump(RAM_DATA);
    @(negedge clk);
    n_checks++;
    if ({dbg_state, mem_addr} !== {DUMP_READ, 8'd0}) begin
      n_fail++; $display("FAIL restart_addr: got state=%0d addr=%0d, required %0d 0", dbg_state, mem_addr, DUMP_READ);
    end
    wait_done(800, ok, nb);
    n_checks++;
    if (!ok || exp_q.size() != 0) begin
      n_fail++; $display("FAIL restart_dump: got done=%b pending=%0d, required 1 0", done, exp_q.size());
    end
    end_session();
  endtask

  task automatic test_checksum();
    bit ok;
    int nb;
    words[0] = 32'h01020304; words[1] = 32'h0; words[2] = 32'h0; words[3] = 32'h0;
    do_load(RAM_INST, 0, ok);
    end_session();
    exp_q.push_back(8'h04); exp_q.push_back(8'h03); exp_q.push_back(8'h02); exp_q.push_back(8'h01);
    for (int i = 0; i < 12; i++) exp_q.push_back(8'h00);
    if (CSUM) exp_q.push_back(8'h0A);
    start_dump(RAM_INST);
    wait_done(800, ok, nb);
    n_checks++;
    if (!ok || exp_q.size() != 0 || nb != (CSUM ? 17 : 16)) begin
      n_fail++; $display("FAIL csum_bytes: got done=%b bytes=%0d pending=%0d, required 1 %0d 0", done, nb, exp_q.size(), CSUM ? 17 : 16);
    end
    n_checks++;
    if (xfer_sum !== (CSUM ? 8'h0A : 8'h00)) begin
      n_fail++; $display("FAIL csum_value: got %h, required %h", xfer_sum, CSUM ? 8'h0A : 8'h00);
    end
    end_session();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load();
    test_abort_load();
    test_dump();
    test_reset_mid_dump();
    test_back_to_back();
    test_checksum();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mem_ctrl.md
Name: uart_mem_ctrl

Overview:
- Sequences UART-driven loading and dumping of the CPU's instruction and data memories.
- Sits between the byte-level UART RX/TX engines, the CPU core, and the memory write/read port.
- While a UART session is active:
  - holds the CPU (cpu_hold=1);
  - takes ownership of the selected memory;
  - streams 32-bit words in (load) or out (dump), little-endian, 4 bytes per word.

Parameters:
- ADDR_WIDTH, 8, word-address width of each memory.
- DEPTH, 256, words transferred per session; must be ≤ 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- uart_on  in  1  session enable (level).
- uart_mode  in  1  0 = load memory from RX, 1 = dump memory to TX.
- uart_ram_id  in  1  0 = instruction memory, 1 = data memory.
- rx_valid  in  1  one-cycle pulse, rx_data valid.
- rx_data  in  8  received byte.
- tx_busy  in  1  TX engine busy; rises the cycle after tx_start.
- tx_start  out  1  one-cycle pulse to send tx_data.
- tx_data  out  8  byte to send.
- mem_sel  out  1  latched uart_ram_id.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  32  write word.
- mem_rdata  in  32  read word, valid 1 cycle after mem_addr.
- cpu_hold  out  1  stall/hold the CPU and mux memory ports to this block.
- busy  out  1  session in progress (state not IDLE/DONE).
- done  out  1  session completed, held until uart_on low.
- word_count  out  ADDR_WIDTH+1  words transferred this session.
- xfer_sum  out  8  running byte checksum (see Optional Feature).

Behaviour:
- Reset (reset=0 at clk edge): state=IDLE; all outputs 0; internal byte index, address and assembly register cleared.
- IDLE:
  - uart_on sampled 1 → latch uart_mode/uart_ram_id, clear word_count and mem_addr, then go to LOAD_BYTE (mode 0) or DUMP_READ (mode 1).
  - Mode/ram_id changes mid-session are ignored.
- cpu_hold=1 in every state except IDLE.
- LOAD_BYTE:
  - Each rx_valid shifts rx_data into byte lane [byte_idx*8 +: 8] (first byte → [7:0]); byte_idx increments.
  - On the 4th byte, next cycle is LOAD_WRITE.
- LOAD_WRITE:
  - Exactly one cycle, mem_we=1 with mem_wdata = assembled word at mem_addr.
  - Then mem_addr+1, word_count+1, byte_idx=0.
  - If word_count reaches DEPTH → DONE, else → LOAD_BYTE.
  - An rx_valid arriving during LOAD_WRITE is captured as byte 0 of the next word; no bytes are lost.
- DUMP_READ: drive mem_addr → DUMP_WAIT (1 cycle) → capture mem_rdata → DUMP_SEND.
- DUMP_SEND:
  - When tx_busy=0, pulse tx_start with byte lane byte_idx → DUMP_TXWAIT.
- DUMP_TXWAIT:
  - Ignore tx_busy in the cycle immediately after the pulse, then wait for tx_busy=0.
  - Then byte_idx+1; after byte 3: mem_addr+1, word_count+1; go to DONE at DEPTH, else DUMP_READ.
- DONE: done=1, cpu_hold=1; uart_on=0 → IDLE (done=0, cpu_hold=0).
- Abort:
  - uart_on=0 in LOAD_*: partial word discarded, no write, → IDLE next cycle.
  - uart_on=0 in DUMP_*: finish the byte currently transmitting (no new tx_start), then → IDLE.
- mem_addr wraps modulo 2^ADDR_WIDTH; never exceeds DEPTH-1 in practice.
- Reset mid-session has priority over everything: immediate return to IDLE, cpu_hold released.

Optional Feature:
- UART_CHECKSUM_EN defined:
  - xfer_sum = mod-256 sum of every byte received (load) or sent (dump), cleared at session start.
  - Dump appends one trailing byte = xfer_sum after the last word, before DONE.
- Undefined: xfer_sum tied to 0; no trailing byte.

Decomposition:
- Shared package/header holds the state encodings (IDLE, LOAD_BYTE, LOAD_WRITE, DUMP_READ, DUMP_WAIT, DUMP_SEND, DUMP_TXWAIT, DONE) and the mode/ram_id constants (MODE_LOAD=0, MODE_DUMP=1, RAM_INST=0, RAM_DATA=1).
- One natural sub-module: uart_word_packer (byte↔word lane select plus byte_idx counter), shared by the load and dump paths.

Test Plan:
- Load:
  - Stimulus: mode 0, ram_id 1, DEPTH=4; RX bytes 78 56 34 12, EF BE AD DE, …
  - Required: mem_we pulses at addr 0 with 0x12345678, addr 1 with 0xDEADBEEF; done=1 after the 4th write; cpu_hold=1 throughout.
- Dump:
  - Stimulus: mode 1; memory holds 0xCAFEBABE at addr 0.
  - Required: tx bytes BE BA FE CA in order; each tx_start only while tx_busy=0; word_count increments per 4 bytes.
- Abort load:
  - Stimulus: uart_on dropped after 2 bytes of word 1.
  - Required: no mem_we for the partial word; IDLE next cycle; cpu_hold=0.
- Back-to-back RX:
  - Stimulus: rx_valid arrives in the LOAD_WRITE cycle.
  - Required: the byte lands in [7:0] of the next word, with no loss.
- Reset mid-dump:
  - Stimulus: reset=0 during DUMP_TXWAIT.
  - Required: all outputs 0 next cycle; new session restarts at addr 0.
- UART_CHECKSUM_EN:
  - Stimulus: dump of a single word 0x01020304.
  - Required: trailing byte 0x0A; xfer_sum=0x0A.
